// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/done handshake and result bus for bin2bcd_seq.
//   master (requester): drives start, bin_in; observes busy, done, bcd_out, overflow.
//   slave  (converter): observes start, bin_in; drives busy, done, bcd_out, overflow.
// IN_WIDTH and DIGITS must match the converter instance attached to it.
interface bin2bcd_seq_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 3
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Converts one IN_WIDTH-bit unsigned value into DIGITS packed BCD digits,
// one bit per clock, over IN_WIDTH cycles in the SHIFT state.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - bin2bcd_seq_if.slave: start, bin_in in; busy, done, bcd_out, overflow out
// Optional feature macro: BIN2BCD_OVF_EN
//   defined   - overflow accumulator implemented; overflow flags a result
//               that did not fit in DIGITS digits
//   undefined - bits leaving the top digit are dropped; overflow tied to 0
module bin2bcd_seq #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [IN_WIDTH-1:0]  r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [BCD_W-1:0]     r_bcd_out;

    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W-1:0]     w_bcd_shift;
    logic                 w_last;

`ifdef BIN2BCD_OVF_EN
    logic                 r_ovf_acc;
    logic                 r_ovf;
    logic                 w_top_bit;
`endif

    // Per-digit add-3 correction; no carry between digits
    always_comb begin
        w_bcd_adj = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            w_bcd_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                           : r_bcd[4*d +: 4];
        end
    end

    // Binary MSB enters BCD bit 0; top BCD bit falls off
    assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[IN_WIDTH-1]};
    assign w_last      = (r_cnt == CNT_W'(IN_WIDTH - 1));

`ifdef BIN2BCD_OVF_EN
    assign w_top_bit = w_bcd_adj[BCD_W-1];
`endif

    // Control FSM and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd_out <= '0;
`ifdef BIN2BCD_OVF_EN
            r_ovf_acc <= 1'b0;
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin   <= bus.bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
`ifdef BIN2BCD_OVF_EN
                        r_ovf_acc <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_shift;
                    r_bin <= {r_bin[IN_WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CNT_W'(1);
`ifdef BIN2BCD_OVF_EN
                    r_ovf_acc <= r_ovf_acc | w_top_bit;
`endif
                    if (w_last) begin
                        // Counter is cleared rather than allowed to wrap
                        r_cnt     <= '0;
                        r_bcd_out <= w_bcd_shift;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
`ifdef BIN2BCD_OVF_EN
                        r_ovf     <= r_ovf_acc | w_top_bit;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd_out;
`ifdef BIN2BCD_OVF_EN
    assign bus.overflow = r_ovf;
`else
    assign bus.overflow = 1'b0;
`endif

endmodule
